// File: rtl/tm_pkg.sv
// Shared definitions for the telemetry serial master: FSM encoding and default timing.
package tm_pkg;

  localparam int unsigned DEF_WORD_W    = 10;
  localparam int unsigned DEF_NUM_WORDS = 52;
  localparam int unsigned DEF_CLK_DIV   = 25;
  localparam int unsigned DEF_LOAD_CYC  = 50;
  localparam int unsigned DEF_SETUP_CYC = 25;
  localparam int unsigned DEF_GAP_CYC   = 50;
  localparam int unsigned IDX_W         = 6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SETUP = 3'd2,
    ST_HI    = 3'd3,
    ST_LO    = 3'd4,
    ST_GAP   = 3'd5,
    ST_DONE  = 3'd6
  } tm_state_e;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tm_data_sync.sv
// Two-flop synchronizer bringing the slave's serial Data line into the clk50 domain.
module tm_data_sync (
  input  logic clk50,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic meta;

  always_ff @(posedge clk50) begin
    if (rst) begin
      meta <= 1'b0;
      dout <= 1'b0;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/tm_serial_master.sv
// Telemetry serial port master: drives Invload/Gtclk bursts, shifts in Data MSB-first
// and presents each completed word with its index within the frame.
module tm_serial_master
  import tm_pkg::*;
#(
  parameter int unsigned WORD_W    = DEF_WORD_W,
  parameter int unsigned NUM_WORDS = DEF_NUM_WORDS,
  parameter int unsigned CLK_DIV   = DEF_CLK_DIV,
  parameter int unsigned LOAD_CYC  = DEF_LOAD_CYC,
  parameter int unsigned SETUP_CYC = DEF_SETUP_CYC,
  parameter int unsigned GAP_CYC   = DEF_GAP_CYC
) (
  input  logic              clk50,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              Gtclk,
  output logic              Invload,
  input  logic              Data,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  output logic [IDX_W-1:0]  word_idx,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned BIT_W   = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int unsigned TMR_MAX = max2(max2(CLK_DIV, LOAD_CYC), max2(SETUP_CYC, GAP_CYC));
  localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  tm_state_e         state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [IDX_W-1:0]  word_q, word_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic              data_s;
  logic              cap;

  tm_data_sync u_sync (
    .clk50 (clk50),
    .rst   (rst),
    .din   (Data),
    .dout  (data_s)
  );

  // Next-state, counter and shift-register logic; the timer restarts on every state change
  always_comb begin
    state_d = state_q;
    timer_d = timer_q + TMR_W'(1);
    bit_d   = bit_q;
    word_d  = word_q;
    shift_d = shift_q;
    cap     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        bit_d   = '0;
        word_d  = '0;
        if (start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (timer_q == TMR_W'(LOAD_CYC - 1)) begin
          state_d = ST_SETUP;
          timer_d = '0;
        end
      end
      ST_SETUP: begin
        if (timer_q == TMR_W'(SETUP_CYC - 1)) begin
          state_d = ST_HI;
          timer_d = '0;
        end
      end
      ST_HI: begin
        // Sample at the end of the high phase, giving the slave's bit time to cross the synchronizer
        if (timer_q == TMR_W'(CLK_DIV - 1)) begin
          state_d = ST_LO;
          timer_d = '0;
          shift_d = WORD_W'({shift_q, data_s});
          cap     = (bit_q == BIT_W'(WORD_W - 1));
        end
      end
      ST_LO: begin
        if (timer_q == TMR_W'(CLK_DIV - 1)) begin
          timer_d = '0;
          if (bit_q == BIT_W'(WORD_W - 1)) begin
            bit_d = '0;
            if (word_q == IDX_W'(NUM_WORDS - 1)) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_GAP;
              word_d  = word_q + IDX_W'(1);
            end
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            state_d = ST_HI;
          end
        end
      end
      ST_GAP: begin
        if (timer_q == TMR_W'(GAP_CYC - 1)) begin
          state_d = ST_HI;
          timer_d = '0;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase

    // Abort beats everything, including a same-cycle start, and drops any partial word
    if (abort) begin
      state_d = ST_IDLE;
      timer_d = '0;
      bit_d   = '0;
      word_d  = '0;
      cap     = 1'b0;
    end
  end

  always_ff @(posedge clk50) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Counters and outputs; strobes are decoded from the upcoming state so they align with it
  always_ff @(posedge clk50) begin
    if (rst) begin
      timer_q    <= '0;
      bit_q      <= '0;
      word_q     <= '0;
      shift_q    <= '0;
      Gtclk      <= 1'b0;
      Invload    <= 1'b1;
      word_out   <= '0;
      word_valid <= 1'b0;
      word_idx   <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      timer_q    <= timer_d;
      bit_q      <= bit_d;
      word_q     <= word_d;
      shift_q    <= shift_d;
      Gtclk      <= (state_d == ST_HI);
      Invload    <= (state_d != ST_LOAD);
      busy       <= (state_d != ST_IDLE);
      frame_done <= (state_d == ST_DONE);
      word_valid <= cap;
      if (cap) begin
        word_out <= shift_d;
        word_idx <= word_q;
      end
    end
  end

endmodule

// File: tb/tb_tm_serial_master.sv
// Directed bench for tm_serial_master with a behavioural slave shifting a fixed 4-word frame.
module tb_tm_serial_master;

  typedef struct {
    logic [9:0] slave_word;
    logic [9:0] exp_word;
    logic [5:0] exp_idx;
  } vec_t;

  vec_t vec [4];

  logic       clk50 = 1'b0;
  logic       rst, start, abort, Data;
  logic       Gtclk, Invload, word_valid, busy, frame_done;
  logic [9:0] word_out;
  logic [5:0] word_idx;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int t0       = 0;
  bit delay_mode = 1'b0;

  int inv_first, inv_last, gt_first, busy_first, busy_last, fd_cnt, fd_rel;
  logic [9:0] wq [$];
  logic [5:0] iq [$];

  int k = 0, kd1 = 0, kd2 = 0;

  tm_serial_master #(
    .WORD_W(10), .NUM_WORDS(4), .CLK_DIV(3), .LOAD_CYC(4), .SETUP_CYC(2), .GAP_CYC(3)
  ) dut (
    .clk50      (clk50),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .Gtclk      (Gtclk),
    .Invload    (Invload),
    .Data       (Data),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_idx   (word_idx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #10 clk50 = ~clk50;
  always @(posedge clk50) cyc <= cyc + 1;

  // Slave: bit pointer restarts on load, advances on each Gtclk falling edge
  function automatic logic bit_of(input int kk);
    logic [9:0] w;
    if (kk < 0 || kk >= 40) return 1'b0;
    w = vec[kk / 10].slave_word;
    return w[9 - (kk % 10)];
  endfunction

  always @(negedge Gtclk or negedge Invload) begin
    if (!Invload) k <= 0;
    else          k <= k + 1;
  end

  always @(posedge clk50) begin
    kd1 <= k;
    kd2 <= kd1;
  end

  always @(*) Data = delay_mode ? bit_of(kd2) : bit_of(k);

  // Monitor: event timing relative to the start cycle
  always @(negedge clk50) begin
    int rel;
    rel = cyc - t0;
    if (Invload !== 1'b1) begin
      if (inv_first < 0) inv_first = rel;
      inv_last = rel;
    end
    if (Gtclk === 1'b1 && gt_first < 0) gt_first = rel;
    if (busy === 1'b1) begin
      if (busy_first < 0) busy_first = rel;
      busy_last = rel;
    end
    if (word_valid === 1'b1) begin
      wq.push_back(word_out);
      iq.push_back(word_idx);
    end
    if (frame_done === 1'b1) begin
      fd_cnt++;
      fd_rel = rel;
    end
  end

  task automatic tick();
    @(negedge clk50);
    #1;
  endtask

  task automatic clear_mon();
    inv_first = -1; inv_last = -1; gt_first = -1;
    busy_first = -1; busy_last = -1; fd_cnt = 0; fd_rel = -1;
    wq.delete();
    iq.delete();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_words();
    check("word_count", wq.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < wq.size()) begin
        check($sformatf("word%0d", i), 32'(wq[i]), 32'(vec[i].exp_word));
        check($sformatf("idx%0d", i), 32'(iq[i]), 32'(vec[i].exp_idx));
      end
    end
  endtask

  task automatic pulse_start();
    clear_mon();
    start = 1'b1;
    t0 = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic run_frame(input bit restart);
    pulse_start();
    for (int n = 0; n < 400 && fd_cnt == 0; n++) begin
      start = (restart && (cyc - t0) == 99);
      tick();
    end
    start = 1'b0;
    repeat (20) tick();
    check("frame_done_count", fd_cnt, 1);
    check("busy_after_frame", 32'(busy), 0);
    check_words();
  endtask

  initial begin
    vec[0] = '{10'h2A5, 10'h2A5, 6'd0};
    vec[1] = '{10'h3FF, 10'h3FF, 6'd1};
    vec[2] = '{10'h000, 10'h000, 6'd2};
    vec[3] = '{10'h155, 10'h155, 6'd3};

    rst = 1'b1; start = 1'b0; abort = 1'b0;
    clear_mon();
    repeat (3) tick();
    rst = 1'b0;
    clear_mon();
    t0 = cyc;
    repeat (20) tick();
    check("idle_gtclk_seen", gt_first, -1);
    check("idle_invload_seen", inv_first, -1);
    check("idle_busy_seen", busy_first, -1);
    check("idle_words", wq.size(), 0);
    check("idle_frame_done", fd_cnt, 0);
    check("idle_word_out", 32'(word_out), 0);
    check("idle_word_idx", 32'(word_idx), 0);

    // Nominal frame with cycle-accurate timing
    run_frame(1'b0);
    check("invload_first", inv_first, 1);
    check("invload_last", inv_last, 4);
    check("gtclk_first_rise", gt_first, 7);
    check("frame_done_cycle", fd_rel, 256);
    check("busy_first", busy_first, 1);
    check("busy_last", busy_last, 256);

    // Restart request mid-frame is ignored
    run_frame(1'b1);
    check("restart_frame_cycle", fd_rel, 256);

    // Abort during the first high phase of word 2
    pulse_start();
    for (int n = 0; n < 400 && !(wq.size() == 2 && Gtclk === 1'b1); n++) tick();
    check("abort_reached_word2", wq.size(), 2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_gtclk", 32'(Gtclk), 0);
    check("abort_invload", 32'(Invload), 1);
    check("abort_busy", 32'(busy), 0);
    repeat (300) tick();
    check("abort_words", wq.size(), 2);
    check("abort_frame_done", fd_cnt, 0);
    check("abort_busy_later", 32'(busy), 0);
    run_frame(1'b0);

    // Reset during the gap after word 1
    pulse_start();
    for (int n = 0; n < 400 && wq.size() < 2; n++) tick();
    repeat (3) tick();
    check("rst_in_gap_busy_before", 32'(busy), 1);
    check("rst_in_gap_gtclk_before", 32'(Gtclk), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_gtclk", 32'(Gtclk), 0);
    check("rst_invload", 32'(Invload), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_word_out", 32'(word_out), 0);
    check("rst_word_idx", 32'(word_idx), 0);
    check("rst_word_valid", 32'(word_valid), 0);
    repeat (10) tick();
    check("rst_no_frame_done", fd_cnt, 0);
    run_frame(1'b0);

    // Slave output lags Gtclk fall by two extra cycles
    delay_mode = 1'b1;
    run_frame(1'b0);
    check("delayed_frame_cycle", fd_rel, 256);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
